// File: rtl/mult_sched_if.sv
// Requester-side bus of the shared-multiplier scheduler: operand requests in, one-hot responses out.
interface mult_sched_if #(
  parameter int BIT_WIDTH = 8,
  parameter int NUM_REQ   = 4
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*BIT_WIDTH-1:0] req_a;
  logic [NUM_REQ*BIT_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [2*BIT_WIDTH-1:0]       rsp_data;
  logic                         rsp_err;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one multi-cycle multiplier among NUM_REQ requesters.
// Optional WAIT timeout abort enabled by defining MULT_SCHED_TIMEOUT_EN.
module mult_sched #(
  parameter int BIT_WIDTH = 8,
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  mult_sched_if.slave            bus,
  output logic                   mult_start,
  output logic [BIT_WIDTH-1:0]   mult_a,
  output logic [BIT_WIDTH-1:0]   mult_b,
  input  logic                   mult_done,
  input  logic [2*BIT_WIDTH-1:0] mult_result,
  output logic                   busy
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                 state_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       gnt_idx_q;
  logic [BIT_WIDTH-1:0]   a_q;
  logic [BIT_WIDTH-1:0]   b_q;
  logic                   mult_start_q;
  logic                   busy_q;
  logic [NUM_REQ-1:0]     rsp_valid_q;
  logic [2*BIT_WIDTH-1:0] rsp_data_q;

  logic [BIT_WIDTH-1:0]   a_arr [NUM_REQ];
  logic [BIT_WIDTH-1:0]   b_arr [NUM_REQ];
  logic [PTR_W-1:0]       cand;
  logic [PTR_W-1:0]       win_idx;
  logic                   win_found;
  logic [NUM_REQ-1:0]     ready;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign a_arr[i] = bus.req_a[i*BIT_WIDTH +: BIT_WIDTH];
    assign b_arr[i] = bus.req_b[i*BIT_WIDTH +: BIT_WIDTH];
  end

  // Search upward from the pointer, wrapping, and take the first valid requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state_q == S_IDLE && win_found) ready[win_idx] = 1'b1;
  end

`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0] tmo_q;
  logic             rsp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      gnt_idx_q    <= '0;
      a_q          <= '0;
      b_q          <= '0;
      mult_start_q <= 1'b0;
      busy_q       <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
`ifdef MULT_SCHED_TIMEOUT_EN
      tmo_q        <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      mult_start_q <= 1'b0;
      rsp_valid_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            a_q          <= a_arr[win_idx];
            b_q          <= b_arr[win_idx];
            gnt_idx_q    <= win_idx;
            mult_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef MULT_SCHED_TIMEOUT_EN
          // Terminal count 0 is reached on the TIMEOUT-th WAIT cycle.
          tmo_q <= TMO_W'(TIMEOUT - 1);
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mult_done) begin
            rsp_data_q             <= mult_result;
            rsp_valid_q[gnt_idx_q] <= 1'b1;
`ifdef MULT_SCHED_TIMEOUT_EN
            rsp_err_q              <= 1'b0;
`endif
            state_q                <= S_RESP;
          end
`ifdef MULT_SCHED_TIMEOUT_EN
          else if (tmo_q == '0) begin
            rsp_data_q             <= '0;
            rsp_valid_q[gnt_idx_q] <= 1'b1;
            rsp_err_q              <= 1'b1;
            state_q                <= S_RESP;
          end else begin
            tmo_q <= tmo_q - TMO_W'(1);
          end
`endif
        end
        S_RESP: begin
          ptr_q   <= (gnt_idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + PTR_W'(1);
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef MULT_SCHED_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif
  assign mult_start    = mult_start_q;
  assign mult_a        = a_q;
  assign mult_b        = b_q;
  assign busy          = busy_q;
endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, operand width.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one multiplier.
REQ-003 SHALL have parameter TIMEOUT, default 32, max WAIT cycles (used only under MULT_SCHED_TIMEOUT_EN).
REQ-004 SHALL have port clk  input  1  sole clock; all state on posedge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester operand-pair valid.
REQ-007 SHALL have port req_a  input  NUM_REQ*BIT_WIDTH  multiplicand, requester i at slice i.
REQ-008 SHALL have port req_b  input  NUM_REQ*BIT_WIDTH  multiplier, requester i at slice i.
REQ-009 SHALL have port req_ready  output  NUM_REQ  one-hot grant; transfer when valid&ready.
REQ-010 SHALL have port rsp_valid  output  NUM_REQ  one-hot, one-cycle response pulse.
REQ-011 SHALL have port rsp_data  output  2*BIT_WIDTH  product for the pulsed requester.
REQ-012 SHALL have port rsp_err  output  1  response is a timeout abort.
REQ-013 SHALL have port mult_start  output  1  one-cycle launch pulse to multiplier.
REQ-014 SHALL have ports mult_a, mult_b  output  BIT_WIDTH each  latched operands.
REQ-015 SHALL have port mult_done  input  1  multiplier completion pulse.
REQ-016 SHALL have port mult_result  input  2*BIT_WIDTH  signed product, sampled on mult_done.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement FSM IDLE->ISSUE->WAIT->RESP->IDLE, one transaction in flight.
REQ-019 IDLE: if any req_valid, SHALL combinationally assert req_ready for the round-robin winner only (search from pointer upward, wrapping), latch its operands and index, go to ISSUE; else stay.
REQ-020 ISSUE: SHALL assert mult_start for exactly one cycle, go to WAIT.
REQ-021 mult_a/mult_b SHALL remain stable from ISSUE until leaving WAIT.
REQ-022 WAIT: on mult_done SHALL register mult_result unmodified (no sign or width change) and go to RESP.
REQ-023 RESP: SHALL pulse rsp_valid[granted] one cycle with rsp_data valid, set pointer = (granted+1) mod NUM_REQ, return to IDLE.
REQ-024 Latency: accept at cycle T, mult_start at T+1, rsp_valid one cycle after mult_done.
REQ-025 rsp_data SHALL hold its last value between responses.
REQ-026 mult_done outside WAIT SHALL be ignored.
REQ-027 req_valid changes outside IDLE SHALL have no effect; req_ready SHALL be all-zero outside IDLE.

Reset
REQ-028 rst SHALL immediately force IDLE, pointer 0, all outputs 0, timeout counter 0.
REQ-029 Reset mid-transaction SHALL discard the transaction with no rsp_valid.

Configuration
REQ-030 With MULT_SCHED_TIMEOUT_EN defined, WAIT SHALL count cycles; on TIMEOUT cycles without mult_done go to RESP with rsp_err=1, rsp_data=0; rsp_err=0 on normal responses.
REQ-031 Without MULT_SCHED_TIMEOUT_EN, WAIT SHALL wait indefinitely and rsp_err SHALL be tied 0.

Verification
REQ-032 req_valid=4'b0001, a=8'h03, b=8'h05, model latency 9 -> mult_start at T+1, rsp_valid=4'b0001, rsp_data=16'h000F at T+11.
REQ-033 a=8'hFD, b=8'h04, model returns 16'hFFF4 -> rsp_data=16'hFFF4, rsp_err=0.
REQ-034 All four valid after reset, held -> grants 0,1,2,3 in order; then only req 1 and 3 valid -> grant 1.
REQ-035 rst pulsed during WAIT -> busy=0, mult_start=0, no rsp_valid; next req_valid=4'b0100 -> granted req 2 (pointer 0, search wraps upward).
REQ-036 mult_done never asserted -> with macro rsp_err=1, rsp_data=0 after 32 WAIT cycles; without macro busy stays 1.
REQ-037 mult_done pulsed in IDLE -> no state change, no rsp_valid.
